// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } state_e;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_REG_W   = 5;
    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load enable and synchronous active-low clear.
module mem_wb
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [1:0]        ctl_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [REG_W-1:0]  reg_i,
    output logic              valid_o,
    output logic [1:0]        ctl_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [REG_W-1:0]  reg_o
);

    logic              valid_q;
    logic [1:0]        ctl_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_W-1:0]  reg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            reg_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            ctl_q   <= ctl_i;
            rdata_q <= rdata_i;
            alu_q   <= alu_i;
            reg_q   <= reg_i;
        end
    end

    assign valid_o = valid_q;
    assign ctl_o   = ctl_q;
    assign rdata_o = rdata_q;
    assign alu_o   = alu_q;
    assign reg_o   = reg_q;

endmodule

// File: rtl/mem_access.sv
// MEM stage: branch resolve, req/ack data-memory port, MEM/WB load and upstream stall.
// Optional bounded WAIT with sticky dmem_timeout under MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned REG_W   = DEF_REG_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [1:0]        wb_ctlout,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata2out,
    input  logic [DATA_W-1:0] add_result,
    input  logic [REG_W-1:0]  five_bit_muxout,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_wb_valid,
    output logic [1:0]        mem_wb_ctl,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic              misalign
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic              dmem_timeout
`endif
);

    state_e state_q, state_d;

    logic              is_mem;
    logic              mis_op;
    logic              mem_op;
    logic              tmo_hit;
    logic [1:0]        wb_fwd;

    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        ctl_q;
    logic [REG_W-1:0]  reg_q;
    logic              misalign_q;

    logic              wb_valid_d;
    logic [1:0]        wb_ctl_d;
    logic [DATA_W-1:0] wb_rdata_d;
    logic [DATA_W-1:0] wb_alu_d;
    logic [REG_W-1:0]  wb_reg_d;

    assign is_mem = ex_valid & (memread | memwrite);
    assign mis_op = is_mem & (alu_result[1:0] != 2'b00);
    assign mem_op = is_mem & ~mis_op;

    // A misaligned access retires as a no-op: WB controls are squashed.
    always_comb begin
        wb_fwd              = wb_ctlout;
        wb_fwd[WB_REGWRITE] = wb_ctlout[WB_REGWRITE] & ~mis_op;
        wb_fwd[WB_MEMTOREG] = wb_ctlout[WB_MEMTOREG] & ~mis_op;
    end

    assign pcsrc         = ex_valid & branch & zero;
    assign branch_target = add_result;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // cnt_q counts completed WAIT cycles; the TIMEOUT-th one aborts unless acked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (cnt_q != CntW'(TIMEOUT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == WAIT) & ~dmem_ack & (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign dmem_timeout = timeout_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        wb_valid_d = 1'b0;
        wb_ctl_d   = '0;
        wb_rdata_d = '0;
        wb_alu_d   = alu_result;
        wb_reg_d   = five_bit_muxout;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall = 1'b1;
                end else begin
                    wb_valid_d = ex_valid;
                    wb_ctl_d   = wb_fwd;
                end
            end
            WAIT: begin
                stall    = ~dmem_ack & ~tmo_hit;
                wb_alu_d = addr_q;
                wb_reg_d = reg_q;
                if (dmem_ack) begin
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = ctl_q;
                    wb_rdata_d = we_q ? '0 : dmem_rdata;
                end else if (tmo_hit) begin
                    wb_valid_d = 1'b1;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    // Request fields and the retiring bundle are captured once on the IDLE->WAIT edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ctl_q   <= '0;
            reg_q   <= '0;
        end else if (state_q == IDLE && mem_op) begin
            req_q   <= 1'b1;
            we_q    <= memwrite;
            addr_q  <= alu_result;
            wdata_q <= rdata2out;
            ctl_q   <= wb_ctlout;
            reg_q   <= five_bit_muxout;
        end else if (state_q == WAIT && (dmem_ack || tmo_hit)) begin
            req_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (state_q == IDLE && mis_op) begin
            misalign_q <= 1'b1;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign misalign   = misalign_q;

    mem_wb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (1'b1),
        .valid_i (wb_valid_d),
        .ctl_i   (wb_ctl_d),
        .rdata_i (wb_rdata_d),
        .alu_i   (wb_alu_d),
        .reg_i   (wb_reg_d),
        .valid_o (mem_wb_valid),
        .ctl_o   (mem_wb_ctl),
        .rdata_o (mem_read_data),
        .alu_o   (mem_alu_result),
        .reg_o   (mem_write_reg)
    );

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: retirement scoreboard plus literal expectations.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] alu_result, rdata2out, add_result;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_wb_valid;
    logic [1:0]  mem_wb_ctl;
    logic [31:0] mem_read_data, mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic        misalign;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        dmem_timeout;
`endif

    always #5 clk = ~clk;

    mem_access #(
        .DATA_W  (32),
        .REG_W   (5),
        .TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .wb_ctlout       (wb_ctlout),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .add_result      (add_result),
        .five_bit_muxout (five_bit_muxout),
        .pcsrc           (pcsrc),
        .branch_target   (branch_target),
        .stall           (stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .mem_wb_valid    (mem_wb_valid),
        .mem_wb_ctl      (mem_wb_ctl),
        .mem_read_data   (mem_read_data),
        .mem_alu_result  (mem_alu_result),
        .mem_write_reg   (mem_write_reg),
        .misalign        (misalign)
`ifdef MEM_ACCESS_TIMEOUT_EN
        ,
        .dmem_timeout    (dmem_timeout)
`endif
    );

    typedef struct packed {
        logic [1:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rg;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        run = 1'b0;
    logic        exp_mis = 1'b0;
    logic [1:0]  last_ctl;
    logic [31:0] last_rdata, last_alu;
    logic [4:0]  last_reg;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (run) begin
            chk("pcsrc_rule", {31'b0, pcsrc}, {31'b0, ex_valid & branch & zero});
            chk("branch_target", branch_target, add_result);
            chk("misalign_sticky", {31'b0, misalign}, {31'b0, exp_mis});
            if (mem_wb_valid === 1'b1) begin
                last_ctl   = mem_wb_ctl;
                last_rdata = mem_read_data;
                last_alu   = mem_alu_result;
                last_reg   = mem_write_reg;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got valid=1 want no retirement at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_ctl", {30'b0, mem_wb_ctl}, {30'b0, e.ctl});
                    chk("ret_rdata", mem_read_data, e.rdata);
                    chk("ret_alu", mem_alu_result, e.alu);
                    chk("ret_reg", {27'b0, mem_write_reg}, {27'b0, e.rg});
                end
            end
        end
    end

    task automatic idle_in();
        ex_valid        = 1'b0;
        wb_ctlout       = 2'b00;
        branch          = 1'b0;
        memread         = 1'b0;
        memwrite        = 1'b0;
        zero            = 1'b0;
        alu_result      = '0;
        rdata2out       = '0;
        add_result      = '0;
        five_bit_muxout = '0;
        dmem_ack        = 1'b0;
        dmem_rdata      = '0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_op(input logic ev, input logic [1:0] wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rg,
                          input int ack_dly, input logic [31:0] rdat, output int stalls);
        logic is_mem, aligned;
        exp_t e;
        stalls  = 0;
        is_mem  = ev & (rd | wr);
        aligned = (alu[1:0] == 2'b00);
        ex_valid = ev; wb_ctlout = wb; memread = rd; memwrite = wr;
        alu_result = alu; rdata2out = wd; five_bit_muxout = rg;
        branch = 1'b0; zero = 1'b0; add_result = 32'h0000_0100;
        e.ctl   = (is_mem && !aligned) ? 2'b00 : wb;
        e.rdata = (is_mem && aligned && rd && !wr) ? rdat : 32'h0;
        e.alu   = alu;
        e.rg    = rg;
        if (ev) exp_q.push_back(e);
        @(negedge clk);
        if (is_mem && aligned) begin
            chk("stall_idle", {31'b0, stall}, 32'd1);
            if (stall) stalls++;
            for (int k = 0; k <= ack_dly; k++) begin
                @(posedge clk); #1;
                dmem_ack   = (k == ack_dly);
                dmem_rdata = (k == ack_dly) ? rdat : (32'hBAD0_0000 | k);
                @(negedge clk);
                chk("req_held", {31'b0, dmem_req}, 32'd1);
                chk("addr_held", dmem_addr, alu);
                chk("we_held", {31'b0, dmem_we}, {31'b0, wr});
                if (wr) chk("wdata_held", dmem_wdata, wd);
                chk("stall_wait", {31'b0, stall}, {31'b0, k != ack_dly});
                chk("bubble", {31'b0, mem_wb_valid}, 32'd0);
                if (stall) stalls++;
            end
        end else begin
            chk("stall_none", {31'b0, stall}, 32'd0);
            chk("no_req", {31'b0, dmem_req}, 32'd0);
        end
        @(posedge clk); #1;
        idle_in();
        if (is_mem && !aligned) exp_mis = 1'b1;
        @(negedge clk);
        chk("latency", {31'b0, mem_wb_valid}, {31'b0, ev});
        chk("req_dropped", {31'b0, dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int st;
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'b0, mem_wb_valid}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_read_data", mem_read_data, 32'd0);
        chk("rst_ctl", {30'b0, mem_wb_ctl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU op: one-cycle latency, never stalls.
        run_op(1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_002A, 32'h0, 5'd9, 0, 32'h0, st);
        chk("alu_stalls", st, 0);
        chk("alu_result_lit", last_alu, 32'h2A);
        chk("alu_reg_lit", {27'b0, last_reg}, 32'd9);
        chk("alu_ctl_lit", {30'b0, last_ctl}, 32'd2);

        // Load with ack three cycles after the request.
        run_op(1'b1, 2'b11, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 3, 32'hDEAD_BEEF, st);
        chk("load_stalls", st, 4);
        chk("load_rdata_lit", last_rdata, 32'hDEAD_BEEF);

        // Store acked in the first WAIT cycle: total latency two.
        run_op(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234, 5'd0, 0, 32'hFFFF_0000, st);
        chk("store_stalls", st, 1);
        chk("store_rdata_lit", last_rdata, 32'h0);
        chk("store_addr_lit", last_alu, 32'h20);

        // Branch taken then not taken.
        ex_valid = 1'b1; branch = 1'b1; zero = 1'b1; add_result = 32'h0000_0040;
        exp_q.push_back('{ctl: 2'b00, rdata: 32'h0, alu: 32'h0, rg: 5'd0});
        @(negedge clk);
        chk("pcsrc_taken_lit", {31'b0, pcsrc}, 32'd1);
        chk("btgt_lit", branch_target, 32'h40);
        #1 zero = 1'b0;
        #1 chk("pcsrc_nottaken_lit", {31'b0, pcsrc}, 32'd0);
        @(posedge clk); #1;
        idle_in();
        @(posedge clk); #1;

        // Read and write together behave as a write.
        run_op(1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0055, 5'd3, 1, 32'hFFFF_FFFF, st);
        chk("rdwr_rdata_lit", last_rdata, 32'h0);

        // Misaligned load: no request, squashed controls, sticky flag.
        run_op(1'b1, 2'b11, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd7, 0, 32'h0, st);
        chk("mis_ctl_lit", {30'b0, last_ctl}, 32'd0);
        chk("mis_flag_lit", {31'b0, misalign}, 32'd1);
        chk("mis_stalls", st, 0);

        run_op(1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0018, 32'h0, 5'd1, 0, 32'h0, st);
        run_op(1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd4, 0, 32'h0, st);

        // Reset in WAIT abandons the access; a late ack is ignored.
        ex_valid = 1'b1; memread = 1'b1; alu_result = 32'h0000_0030; five_bit_muxout = 5'd6;
        wb_ctlout = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_req_up", {31'b0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_in();
        @(posedge clk); #1;
        exp_mis = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_req_down", {31'b0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'b0, stall}, 32'd0);
        chk("rstw_valid", {31'b0, mem_wb_valid}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_valid", {31'b0, mem_wb_valid}, 32'd0);
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        @(posedge clk); #1;

        run_op(1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 5'd8, 0, 32'h0, st);
        chk("post_rst_alu_lit", last_alu, 32'h99);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack: abort after four WAIT cycles and retire as a no-op.
        ex_valid = 1'b1; memread = 1'b1; alu_result = 32'h0000_0050; five_bit_muxout = 5'd2;
        wb_ctlout = 2'b11;
        exp_q.push_back('{ctl: 2'b00, rdata: 32'h0, alu: 32'h50, rg: 5'd2});
        @(negedge clk);
        chk("tmo_stall_idle", {31'b0, stall}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("tmo_req", {31'b0, dmem_req}, 32'd1);
            chk("tmo_stall", {31'b0, stall}, {31'b0, k != 3});
        end
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("tmo_retire", {31'b0, mem_wb_valid}, 32'd1);
        chk("tmo_flag", {31'b0, dmem_timeout}, 32'd1);
        chk("tmo_req_down", {31'b0, dmem_req}, 32'd0);
        chk("tmo_stall_rel", {31'b0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("tmo_sticky", {31'b0, dmem_timeout}, 32'd1);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage pipeline. It is the consumer end of the EX/MEM interface.
- It takes the EX/MEM bundle (WB/M controls, ALU result, store data, branch target, zero flag, destination register) and drives a req/ack data-memory port.
- It resolves the branch (pcsrc) and loads the MEM/WB pipeline register.
- It stalls upstream stages while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, destination register index width.
- TIMEOUT, 16, maximum WAIT cycles before error (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- ex_valid  in  1  EX/MEM bundle holds a real instruction
- wb_ctlout  in  2  WB controls; [1] regwrite, [0] memtoreg
- branch  in  1  branch instruction
- memread  in  1  load
- memwrite  in  1  store
- zero  in  1  ALU zero flag
- alu_result  in  DATA_W  memory address or ALU result
- rdata2out  in  DATA_W  store data
- add_result  in  DATA_W  branch target
- five_bit_muxout  in  REG_W  destination register
- pcsrc  out  1  take branch
- branch_target  out  DATA_W  equals add_result
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data; valid while dmem_ack
- dmem_ack  in  1  access complete, one-cycle pulse
- mem_wb_valid  out  1  MEM/WB holds a real instruction
- mem_wb_ctl  out  2  registered wb_ctlout
- mem_read_data  out  DATA_W  registered load data
- mem_alu_result  out  DATA_W  registered alu_result
- mem_write_reg  out  REG_W  registered five_bit_muxout
- misalign  out  1  sticky: memory op with alu_result[1:0] != 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low (rst_n). On reset every registered output is 0, and the FSM goes to IDLE.
- Definitions:
  - mem_op = ex_valid & (memread | memwrite) & (alu_result[1:0] == 0).
  - If memread and memwrite are both set, the op is a write; mem_read_data is loaded with 0.
- pcsrc = ex_valid & branch & zero. It is combinational and not gated by stall. branch_target = add_result.
- FSM IDLE:
  - Not mem_op: at the next edge, load MEM/WB from the inputs. mem_wb_valid = ex_valid; mem_read_data = 0. stall = 0.
  - mem_op: stall = 1 combinationally. At the next edge, go to WAIT and register dmem_req = 1, dmem_we = memwrite, dmem_addr = alu_result, dmem_wdata = rdata2out. Load mem_wb_valid = 0 (bubble).
- FSM WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable. stall = ~dmem_ack.
  - Each edge with dmem_ack = 0 loads mem_wb_valid = 0.
  - On the edge where dmem_ack = 1: load MEM/WB (mem_read_data = dmem_rdata for a read, 0 for a write; mem_wb_valid = 1). Drop dmem_req and return to IDLE. Upstream advances on that same edge.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 2 cycles plus the number of WAIT cycles with ack low. Minimum is 2 (ack in the first WAIT cycle).
- Inputs are held by upstream while stall = 1. The block does not re-sample them in WAIT; the request fields are those registered on the IDLE to WAIT edge.
- Misaligned access:
  - No request is issued. The instruction passes as a non-memory op with mem_wb_ctl forced to 0.
  - misalign goes to 1 and stays set until reset.
- dmem_ack while in IDLE is ignored.
- rst_n low in WAIT: the FSM returns to IDLE, dmem_req drops, and the pending access is abandoned. A late ack is ignored by the IDLE rule.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - An internal counter counts WAIT cycles. It is $clog2(TIMEOUT+1) bits wide, clears on entry to WAIT, and saturates.
  - On reaching TIMEOUT with no ack: abort to IDLE and drop dmem_req. Load MEM/WB with mem_wb_valid = 1 and mem_wb_ctl = 0 (retire as a no-op). Set the extra output port dmem_timeout, which is sticky until reset.
  - A dmem_ack arriving on the timeout cycle wins.
- Undefined: the dmem_timeout port is absent and WAIT is unbounded.

Decomposition:
- Package mem_pkg holds:
  - the state typedef {IDLE, WAIT};
  - localparams WB_REGWRITE = 1 and WB_MEMTOREG = 0;
  - the default widths.
- Sub-module mem_wb: the MEM/WB pipeline register with load enable and synchronous active-low clear. mem_access instantiates it once.

Test Plan:
- ALU op: ex_valid = 1, no mem, alu_result = 0x0000_002A, five_bit_muxout = 9, wb = 2'b10 -> next cycle mem_wb_valid = 1, mem_alu_result = 0x2A, mem_write_reg = 9, stall never 1.
- Load with ack 3 cycles after req, dmem_rdata = 0xDEAD_BEEF, addr 0x10:
  - stall is high for 4 cycles;
  - dmem_addr is 0x10 stable throughout;
  - mem_read_data = 0xDEADBEEF with mem_wb_valid = 1 exactly once;
  - the bubbles before it have mem_wb_valid = 0.
- Store to 0x20, data 0x1234, ack in the first WAIT cycle -> dmem_we = 1, dmem_wdata = 0x1234, total latency 2 cycles, mem_read_data = 0.
- Branch: branch = 1, zero = 1, add_result = 0x40 -> pcsrc = 1 and branch_target = 0x40 in the same cycle. With zero = 0 -> pcsrc = 0.
- Misaligned load at 0x13 -> no dmem_req, misalign = 1 sticky, mem_wb_ctl = 0. Reset asserted mid-WAIT -> dmem_req = 0 and FSM in IDLE on the next edge.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT = 4, no ack -> abort after 4 WAIT cycles, dmem_timeout = 1, stall released.
